// File: rtl/pipelined_adder.sv
// pipelined_adder: valid/ready add/subtract unit split into STAGES carry-ripple chunks with registered carries.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic             w_adv;
  logic [STAGES:0]  r_v;
  logic [STAGES:0]  r_c;
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES+1];
  logic [CHUNK:0]   w_add [STAGES];
  logic [WIDTH-1:0] w_s [STAGES];
  logic             w_ovf;
  logic             w_zero;
  logic             r_ovf;
  logic             r_zero;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Index 0 is the operand register; entry k+1 holds the sum with chunks 0..k completed.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_add[k] = {1'b0, r_a[k][k*CHUNK +: CHUNK]} + {1'b0, r_b[k][k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, r_c[k]};
      w_s[k] = r_s[k];
      w_s[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
    end
  end

  assign w_ovf  = r_v[STAGES-1] && (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1])
                  && (w_s[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);
  assign w_zero = r_v[STAGES-1] && (w_s[STAGES-1] == '0);

  // Bubbles carry all-zero data so idle outputs stay at their reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v    <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) r_s[k] <= '0;
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      r_a[0] <= in_valid ? a : '0;
      r_b[0] <= in_valid ? (sub ? ~b : b) : '0;
      r_c[0] <= in_valid && (sub || cin);
      r_s[0] <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_v[k+1] <= r_v[k];
        r_c[k+1] <= w_add[k][CHUNK];
        r_s[k+1] <= w_s[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        r_a[k+1] <= r_a[k];
        r_b[k+1] <= r_b[k];
      end
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign out_valid = r_v[STAGES];
  assign sum       = r_s[STAGES];
  assign cout      = r_c[STAGES];
  assign overflow  = r_ovf;
  assign zero      = r_zero;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: random and directed stimulus checked against a signed/unsigned arithmetic model.
module tb_pipelined_adder;
  localparam int STAGES = 4;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          acc;
    int          stl;
    bit          seen;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic        sub = 0;
  logic        cin = 0;
  logic [31:0] a = 0;
  logic [31:0] b = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   stall_cnt = 0;
  bit   mon_on = 0;
  exp_t q[$];

  pipelined_adder #(.WIDTH(32), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub), .cin(cin),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Subtraction uses true signed/unsigned differences; addition uses widened sums.
  function automatic exp_t model(logic [31:0] x, logic [31:0] y, logic s_, logic c_);
    exp_t m;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r;
    logic [32:0] u;
    m = '{default: 0};
    if (s_) begin
      r = sx - sy;
      m.s = x - y;
      m.c = (x >= y);
    end else begin
      r = sx + sy + (c_ ? 64'sd1 : 64'sd0);
      u = {1'b0, x} + {1'b0, y} + {32'd0, c_};
      m.s = u[31:0];
      m.c = u[32];
    end
    m.o = (r > SMAX) || (r < SMIN);
    m.z = (m.s == 32'd0);
    return m;
  endfunction

  always @(negedge clk) if (mon_on) begin
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        if (!q[0].seen) begin
          chk("latency", edge_cnt, q[0].acc + STAGES + stall_cnt - q[0].stl);
          q[0].seen = 1;
        end
        chk("sum", sum, q[0].s);
        chk("cout", cout, q[0].c);
        chk("overflow", overflow, q[0].o);
        chk("zero", zero, q[0].z);
        if (out_ready && !rst) void'(q.pop_front());
      end
    end
    if (!in_ready) stall_cnt++;
    if (rst) q.delete();
    else if (in_valid && in_ready) begin
      exp_t e;
      e = model(a, b, sub, cin);
      e.acc = edge_cnt + 1;
      e.stl = stall_cnt;
      q.push_back(e);
    end
  end

  task automatic chk_idle(string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_sum"}, sum, 0);
    chk({nm, "_flags"}, {cout, overflow, zero}, 0);
  endtask

  task automatic one_op(string nm, logic [31:0] x, logic [31:0] y, logic s_, logic c_,
                        logic [31:0] es, logic ec, logic eo, logic ez);
    @(posedge clk); #1;
    out_ready = 1; in_valid = 1; a = x; b = y; sub = s_; cin = c_;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (STAGES - 1) @(posedge clk);
    #1 chk({nm, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, overflow, eo);
    chk({nm, "_zero"}, zero, ez);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0; out_ready = 1;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic stream(int n, bit bp);
    int sent = 0;
    int cyc = 0;
    int stl = 0;
    bit fresh = 1;
    while (sent < n && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (bp && stl == 0 && out_valid && $urandom_range(0, 3) == 0) stl = 3;
      out_ready = (stl == 0) && (!bp || out_valid || $urandom_range(0, 1) == 1);
      if (stl > 0) stl--;
      if (fresh) begin
        in_valid = bp ? ($urandom_range(0, 4) != 0) : 1'b1;
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
      end
      @(negedge clk);
      fresh = !in_valid || in_ready;
      if (in_valid && in_ready) sent++;
    end
    chk("stream_sent", sent, n);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    drain();
  endtask

  initial begin
    in_valid = 1; a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1;
    @(posedge clk); #1;
    mon_on = 1;
    chk_idle("rst1");
    chk("rst1_ready", in_ready, 1);
    @(posedge clk); #1;
    chk_idle("rst2");
    rst = 0; in_valid = 0;
    for (int i = 0; i <= STAGES; i++) begin
      @(posedge clk); #1;
      chk_idle("post_rst");
    end

    one_op("carry_chain", 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 32'h0000_0000, 1, 0, 1);
    one_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 1, 1, 0);
    one_op("sub_neg", 32'd5, 32'd7, 1, 1, 32'hFFFF_FFFE, 0, 0, 0);
    one_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0);

    stream(16, 0);
    stream(40, 1);

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = $urandom; b = $urandom; sub = $urandom_range(0, 1); cin = 1;
      @(posedge clk); #1;
    end
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_idle("flush");
    one_op("after_flush", 32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0, 0);
    repeat (STAGES + 2) @(posedge clk);
    #1 chk("final_q", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit for the CPU datapath. It supersedes the fixed 32-bit combinational ripple adder wherever the adder sits on a critical path. It splits a WIDTH-bit operation into STAGES equal carry-ripple chunks, with a registered carry between chunks. It accepts one operation per cycle under a valid/ready handshake and returns the sum plus status flags (carry, signed overflow, zero) a fixed number of cycles later.

## Interface
- WIDTH, 32: operand and result width in bits; must be ≥ 2.
- STAGES, 4: number of pipeline stages; WIDTH % STAGES must be 0, else elaboration error. CHUNK = WIDTH/STAGES.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation this cycle.
- sub  input  1  0: a + b + cin; 1: a + ~b + 1 (cin ignored).
- cin  input  1  carry-in for add mode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1 (sub mode: 1 = no borrow).
- overflow  output  1  signed overflow: operand sign bits equal after B-inversion, result sign differs.
- zero  output  1  sum == 0.

## Operation
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of A and effective B (b or ~b) with the carry registered from stage k-1. Stage 0 uses carry-in = sub ? 1 : cin.
- Operand chunks not yet consumed travel in skew registers alongside; completed sum chunks are carried forward, so sum is assembled in the final stage register.
- Each stage holds a valid bit. The pipeline moves as one unit: advance = !out_valid || out_ready.
- in_ready = advance (combinational); an operation is accepted when in_valid && in_ready.
- When advance = 1, every stage loads from its predecessor; stage 0 loads the accepted operation, or a bubble (valid = 0) if none. When advance = 0, all stages hold, including sum and flags.
- Bubbles are not collapsed: the stall rule is global.
- Flags are computed in the last stage from the full result and the MSB operand bits carried there. They are registered with sum and are stable while out_valid && !out_ready.
- Reset clears every valid bit and every data/carry register to 0. Outputs after reset: out_valid=0, sum=0, cout=0, overflow=0, zero=0, in_ready=1.
- Reset mid-operation flushes all in-flight operations with no output. The cycle after rst deasserts behaves as an empty pipeline.
- STAGES=1 degenerates to a single registered WIDTH-bit adder with the same handshake.

## Timing
- Latency: an operation accepted at edge N shows out_valid=1 with its result after edge N+STAGES, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: one operation per cycle while out_ready=1.
- A result transfers on any edge with out_valid && out_ready. The same edge may accept a new input, since in_ready=1 when out_ready=1.
- out_ready may be low while out_valid=0; this does not stall the unit (advance=1).
- Longest combinational path: one CHUNK-bit ripple plus flag logic in the last stage.
- in_ready depends combinationally on out_ready and out_valid only, never on in_valid.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1. Required: out_valid=0, sum=0, flags=0 throughout and STAGES cycles after release, with no spurious result.
- Add/carry chain, WIDTH=32, STAGES=4: a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0. Required: 4 cycles later sum=0x00000000, cout=1, zero=1, overflow=0. The carry must cross all chunk boundaries.
- Subtract/overflow: a=0x80000000, b=0x00000001, sub=1. Required: sum=0x7FFFFFFF, cout=1, overflow=1, zero=0. Also a=5, b=7, sub=1 gives sum=0xFFFFFFFE, cout=0, overflow=0.
- Back-to-back streaming: 16 random operations on consecutive cycles with out_ready=1. Required: results in order, one per cycle, first at cycle 4, each matching a reference model.
- Backpressure: stream operations, drop out_ready for 3 cycles while out_valid=1. Required: in_ready=0 during the stall, sum and flags held stable, nothing lost or duplicated, order preserved after release.
- Reset mid-flight: accept 3 operations, assert rst for 1 cycle. Required: none of the 3 appear on the output; the next accepted operation emerges exactly STAGES cycles after its acceptance.
